inst_rom_loader: RTL and testbench

//  Byte-stream boot loader: writer side of the instruction ROM that the pipeline CPU reads via rom_addr/inst.

---
 rtl/inst_rom_loader_pkg.sv | 23 ++
 rtl/inst_rom_loader_word_packer.sv | 37 +++
 rtl/inst_rom_loader.sv | 143 ++++++++++++++
 tb/tb_inst_rom_loader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_loader_pkg.sv
// Shared widths and loader state encoding for the instruction ROM boot loader.
package inst_rom_loader_pkg;

  localparam int unsigned InstDataWidth = 32;
  localparam int unsigned ByteWidth     = 8;
  localparam int unsigned CntWidth      = 16;
  localparam int unsigned LdrStateWidth = 3;

  typedef enum logic [LdrStateWidth-1:0] {
    LDR_HDR_HI = 3'd0,
    LDR_HDR_LO = 3'd1,
    LDR_LOAD   = 3'd2,
    LDR_CHK    = 3'd3,
    LDR_DONE   = 3'd4,
    LDR_ERR    = 3'd5
  } ldr_state_e;

  // States in which the loader takes bytes from the stream.
  function automatic logic ldr_accepting(input ldr_state_e s);
    return (s == LDR_HDR_HI) || (s == LDR_HDR_LO) || (s == LDR_LOAD) || (s == LDR_CHK);
  endfunction

endpackage

// File: rtl/inst_rom_loader_word_packer.sv
// Packs four stream bytes into one big-endian 32-bit word (first byte -> [31:24]).
module loader_word_packer
  import inst_rom_loader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     shift_en,
  input  logic [ByteWidth-1:0]     byte_in,
  output logic                     word_done_c,
  output logic [InstDataWidth-1:0] word_c
);

  localparam int unsigned ShWidth = InstDataWidth - ByteWidth;

  logic [1:0]         byte_idx_q;
  logic [ShWidth-1:0] shreg_q;

  // The 4th byte completes the word combinationally; the top registers it.
  assign word_done_c = shift_en && (byte_idx_q == 2'd3);
  assign word_c      = {shreg_q, byte_in};

  // Byte index counter and shift register for the first three bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx_q <= 2'd0;
      shreg_q    <= '0;
    end else if (clear) begin
      byte_idx_q <= 2'd0;
      shreg_q    <= '0;
    end else if (shift_en) begin
      byte_idx_q <= byte_idx_q + 2'd1;
      shreg_q    <= {shreg_q[ShWidth-ByteWidth-1:0], byte_in};
    end
  end

endmodule

// File: rtl/inst_rom_loader.sv
// Framed byte-stream boot loader writing the instruction ROM and holding the CPU until a good image is in.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int unsigned InstMemNum = 32,
  parameter int unsigned AddrBits   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ByteWidth-1:0]     in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     rom_we,
  output logic [AddrBits-1:0]      rom_waddr,
  output logic [InstDataWidth-1:0] rom_wdata,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     err,
  output logic [AddrBits:0]        words_loaded
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(InstMemNum);

  ldr_state_e state_q, state_d;

  logic                     in_ready_q;
  logic                     rom_we_q;
  logic [AddrBits-1:0]      rom_waddr_q;
  logic [InstDataWidth-1:0] rom_wdata_q;
  logic                     cpu_hold_q;
  logic                     done_q;
  logic                     err_q;
  logic [AddrBits:0]        words_loaded_q;
  logic [AddrBits-1:0]      word_idx_q;
  logic [ByteWidth-1:0]     xor_q;
  logic [ByteWidth-1:0]     cnt_hi_q;
  logic [CntWidth-1:0]      cnt_q;

  logic                     accept_c;
  logic                     arm_c;
  logic                     load_shift_c;
  logic                     last_word_c;
  logic [CntWidth-1:0]      cnt_c;
  logic                     word_done_c;
  logic [InstDataWidth-1:0] word_c;

  // in_ready_q mirrors the accepting states of state_q, so it doubles as the state qualifier.
  assign accept_c     = in_valid && in_ready_q;
  assign arm_c        = start && ((state_q == LDR_DONE) || (state_q == LDR_ERR));
  assign load_shift_c = accept_c && (state_q == LDR_LOAD);
  assign cnt_c        = {cnt_hi_q, in_data};
  assign last_word_c  = (CntWidth'(words_loaded_q) + CntWidth'(1)) == cnt_q;

  loader_word_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear       (arm_c),
    .shift_en    (load_shift_c),
    .byte_in     (in_data),
    .word_done_c (word_done_c),
    .word_c      (word_c)
  );

  // Loader state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LDR_HDR_HI;
    else      state_q <= state_d;
  end

  // Frame sequencing: header, payload words, checksum, then sticky DONE/ERR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LDR_HDR_HI: if (accept_c) state_d = LDR_HDR_LO;
      LDR_HDR_LO: begin
        if (accept_c) begin
          if (cnt_c > MaxCnt)           state_d = LDR_ERR;
          else if (cnt_c == '0)         state_d = LDR_CHK;
          else                          state_d = LDR_LOAD;
        end
      end
      LDR_LOAD:   if (word_done_c && last_word_c) state_d = LDR_CHK;
      LDR_CHK: begin
        if (accept_c) state_d = (in_data == xor_q) ? LDR_DONE : LDR_ERR;
      end
      LDR_DONE,
      LDR_ERR:    if (start) state_d = LDR_HDR_HI;
      default:    state_d = LDR_HDR_HI;
    endcase
  end

  // Output registers, running checksum, header latch and word counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_q     <= 1'b0;
      rom_we_q       <= 1'b0;
      rom_waddr_q    <= '0;
      rom_wdata_q    <= '0;
      cpu_hold_q     <= 1'b1;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      words_loaded_q <= '0;
      word_idx_q     <= '0;
      xor_q          <= '0;
      cnt_hi_q       <= '0;
      cnt_q          <= '0;
    end else begin
      in_ready_q <= ldr_accepting(state_d);
      rom_we_q   <= word_done_c;
      done_q     <= (state_d == LDR_DONE);
      err_q      <= (state_d == LDR_ERR);
      cpu_hold_q <= (state_d != LDR_DONE);
      if (arm_c) begin
        words_loaded_q <= '0;
        word_idx_q     <= '0;
        xor_q          <= '0;
        cnt_hi_q       <= '0;
        cnt_q          <= '0;
      end else begin
        if (accept_c && (state_q != LDR_CHK)) xor_q <= xor_q ^ in_data;
        if (accept_c && (state_q == LDR_HDR_HI)) cnt_hi_q <= in_data;
        if (accept_c && (state_q == LDR_HDR_LO)) cnt_q <= cnt_c;
        if (word_done_c) begin
          rom_wdata_q    <= word_c;
          rom_waddr_q    <= word_idx_q;
          word_idx_q     <= word_idx_q + AddrBits'(1);
          words_loaded_q <= words_loaded_q + (AddrBits+1)'(1);
        end
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign rom_we       = rom_we_q;
  assign rom_waddr    = rom_waddr_q;
  assign rom_wdata    = rom_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: frame table plus reset/start corner sequences.
module tb_inst_rom_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        rom_we;
  logic [4:0]  rom_waddr;
  logic [31:0] rom_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [5:0]  words_loaded;

  inst_rom_loader #(.InstMemNum(32), .AddrBits(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .rom_we       (rom_we),
    .rom_waddr    (rom_waddr),
    .rom_wdata    (rom_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] cnt;
    bit          flip;
    bit          gaps;
    bit          fixed;
    logic        exp_done;
    logic        exp_err;
    int          exp_words;
  } vec_t;

  wr_t         sb[$];
  logic [31:0] pay[32];
  vec_t        vecs[6];
  int          tests = 0;
  int          fails = 0;
  int          writes_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ROM write monitor: every strobe must match the next scoreboard entry.
  always @(negedge clk) begin
    wr_t e;
    if (rom_we === 1'b1) begin
      writes_seen++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0h data %0h with empty scoreboard", rom_waddr, rom_wdata);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(rom_waddr), 32'(e.addr));
        check("wr_data", rom_wdata, e.data);
      end
    end
  end

  // Offer one byte; returns #1 after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    int n;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    forever begin
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Re-arm from DONE/ERR, optionally with a byte offered in the same cycle.
  task automatic arm(input bit collide);
    start = 1'b1;
    if (collide) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    check("arm_done", 32'(done), 32'd0);
    check("arm_err", 32'(err), 32'd0);
    check("arm_hold", 32'(cpu_hold), 32'd1);
    check("arm_words", 32'(words_loaded), 32'd0);
    check("arm_ready", 32'(in_ready), 32'd1);
  endtask

  // Send a whole frame; start is pulsed after word start_at (if >= 0).
  task automatic run_frame(input logic [15:0] cnt, input bit flip, input bit gaps, input int start_at);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    send_byte(cnt[15:8], gaps);
    x = x ^ cnt[15:8];
    send_byte(cnt[7:0], gaps);
    x = x ^ cnt[7:0];
    if (cnt > 16'd32) return;
    for (int w = 0; w < int'(cnt); w++) begin
      for (int k = 0; k < 4; k++) begin
        b = pay[w][31-8*k -: 8];
        if (k == 3) sb.push_back({5'(w), pay[w]});
        send_byte(b, gaps);
        x = x ^ b;
        if (k == 3) check("wr_latency", 32'(rom_we), 32'd1);
      end
      if (w == start_at) begin
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_ign_words", 32'(words_loaded), 32'(w + 1));
        check("start_ign_ready", 32'(in_ready), 32'd1);
        check("start_ign_hold", 32'(cpu_hold), 32'd1);
      end
    end
    send_byte(flip ? (x ^ 8'h5A) : x, gaps);
  endtask

  task automatic fill_pay(input bit fixed);
    for (int i = 0; i < 32; i++) pay[i] = $urandom;
    if (fixed) begin
      pay[0] = 32'h34010005;
      pay[1] = 32'h3402000A;
      pay[2] = 32'h00221820;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ws0;
    vecs[0] = '{16'd3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3};
    vecs[1] = '{16'd3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3};
    vecs[2] = '{16'd33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[3] = '{16'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[4] = '{16'd32, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32};
    vecs[5] = '{16'd1,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};

    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(rom_we), 32'd0);
    check("rst_waddr", 32'(rom_waddr), 32'd0);
    check("rst_wdata", rom_wdata, 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // Frame table: each entry is a whole frame followed by a sticky-status check.
    for (int i = 0; i < 6; i++) begin
      if (i > 0) arm(i == 2);
      fill_pay(vecs[i].fixed);
      ws0 = writes_seen;
      run_frame(vecs[i].cnt, vecs[i].flip, vecs[i].gaps, -1);
      check("v_done", 32'(done), 32'(vecs[i].exp_done));
      check("v_err", 32'(err), 32'(vecs[i].exp_err));
      check("v_hold", 32'(cpu_hold), 32'(!vecs[i].exp_done));
      check("v_ready", 32'(in_ready), 32'd0);
      check("v_words", 32'(words_loaded), 32'(vecs[i].exp_words));
      repeat (2) @(posedge clk);
      #1;
      check("v_writes", 32'(writes_seen - ws0), 32'(vecs[i].exp_words));
      check("v_sticky_done", 32'(done), 32'(vecs[i].exp_done));
      check("v_sticky_err", 32'(err), 32'(vecs[i].exp_err));
      check("v_sb_empty", 32'(sb.size()), 32'd0);
    end

    // Reset mid-frame: one word written, second word half packed, then reset.
    arm(1'b0);
    fill_pay(1'b0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) sb.push_back({5'd0, pay[0]});
      send_byte(pay[0][31-8*k -: 8], 1'b1);
    end
    send_byte(pay[1][31:24], 1'b1);
    send_byte(pay[1][23:16], 1'b1);
    ws0 = writes_seen;
    rst = 1'b0;
    #1;
    check("midrst_we", 32'(rom_we), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_words", 32'(words_loaded), 32'd0);
    check("midrst_waddr", 32'(rom_waddr), 32'd0);
    check("midrst_hold", 32'(cpu_hold), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_no_write", 32'(writes_seen - ws0), 32'd0);
    fill_pay(1'b0);
    run_frame(16'd2, 1'b0, 1'b1, -1);
    check("reload_done", 32'(done), 32'd1);
    check("reload_words", 32'(words_loaded), 32'd2);

    // start during LOAD is ignored; start in DONE re-arms and reloads from address 0.
    arm(1'b0);
    fill_pay(1'b0);
    run_frame(16'd2, 1'b0, 1'b0, 0);
    check("ldstart_done", 32'(done), 32'd1);
    check("ldstart_words", 32'(words_loaded), 32'd2);
    arm(1'b1);
    fill_pay(1'b1);
    run_frame(16'd3, 1'b0, 1'b0, -1);
    check("rearm_done", 32'(done), 32'd1);
    check("rearm_hold", 32'(cpu_hold), 32'd0);
    check("rearm_words", 32'(words_loaded), 32'd3);
    repeat (2) @(posedge clk);
    #1;
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
